// File: rtl/uart_program_loader_pkg.sv
// Shared constants, FSM state types and the high-byte range check for the UART program loader.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_COUNT = 2'd1,
        L_HI    = 2'd2,
        L_LO    = 2'd3
    } loader_state_t;

    // A high byte is bad when any bit above the part that fits in the program word is set.
    function automatic logic hi_byte_bad(input logic [7:0] b, input int unsigned keep_bits);
        return (b >> keep_bits) != 8'd0;
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Program-memory write port and load status, driven by the loader (master) into the text RAM side (slave).
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
);
    logic                  program_write;
    logic [ADDR_WIDTH-1:0] program_address;
    logic [DATA_WIDTH-1:0] program_cmd;
    logic                  loading;
    logic                  load_done;
    logic                  load_error;

    modport master (
        output program_write, program_address, program_cmd,
        output loading, load_done, load_error
    );

    modport slave (
        input program_write, program_address, program_cmd,
        input loading, load_done, load_error
    );
endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] data_o,
    output logic       frame_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state_q, state_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             bit_end_s;

    assign bit_end_s = (cnt_q == BIT_LAST);

    // State register, synchroniser and datapath registers; the line idles high so sync flops reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RX_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (rx_prev_q && !rx_sync_q) state_d = RX_START; else state_d = RX_IDLE;
            RX_START: if (cnt_q == HALF_LAST) state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                      else state_d = RX_START;
            RX_DATA:  if (bit_end_s && bit_idx_q == 3'd7) state_d = RX_STOP; else state_d = RX_DATA;
            RX_STOP:  if (bit_end_s) state_d = RX_IDLE; else state_d = RX_STOP;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Bit timing, shift register and the registered result pulses.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
            end
            RX_START: if (cnt_q == HALF_LAST) cnt_d = '0; else cnt_d = cnt_q + CNT_W'(1);
            RX_DATA: begin
                if (bit_end_s) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (bit_end_s) begin
                    cnt_d        = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign data_o       = shift_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image (sync, word count, hi/lo byte pairs) from a UART into text RAM.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT      = 434,
    parameter int ADDR_WIDTH        = 8,
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    uart_program_loader_if.master prog_bus
);
    localparam int unsigned HI_BITS = DATA_WIDTH - 8;

    logic            byte_valid_s, frame_err_s;
    logic [7:0]      byte_data_s;
    logic            hi_bad_s;

    loader_state_t         l_state_q, l_state_d;
    logic [8:0]            remaining_q, remaining_d;
    logic [HI_BITS-1:0]    hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic                  write_q, write_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx),
        .byte_valid_o (byte_valid_s),
        .data_o       (byte_data_s),
        .frame_err_o  (frame_err_s)
    );

    assign hi_bad_s = hi_byte_bad(byte_data_s, HI_BITS);

    // State register and all loader datapath / output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_state_q   <= L_IDLE;
            remaining_q <= 9'd0;
            hi_q        <= '0;
            cur_addr_q  <= '0;
            addr_q      <= '0;
            cmd_q       <= '0;
            write_q     <= 1'b0;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            l_state_q   <= l_state_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            cur_addr_q  <= cur_addr_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            write_q     <= write_d;
            loading_q   <= loading_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic; a framing error outside idle always drops back to idle.
    always_comb begin
        l_state_d = l_state_q;
        case (l_state_q)
            L_IDLE:  if (byte_valid_s && byte_data_s == SYNC_BYTE) l_state_d = L_COUNT;
                     else l_state_d = L_IDLE;
            L_COUNT: if (frame_err_s) l_state_d = L_IDLE;
                     else if (byte_valid_s) l_state_d = L_HI;
                     else l_state_d = L_COUNT;
            L_HI:    if (frame_err_s) l_state_d = L_IDLE;
                     else if (byte_valid_s) l_state_d = hi_bad_s ? L_IDLE : L_LO;
                     else l_state_d = L_HI;
            L_LO:    if (frame_err_s) l_state_d = L_IDLE;
                     else if (byte_valid_s) l_state_d = (remaining_q == 9'd1) ? L_IDLE : L_HI;
                     else l_state_d = L_LO;
            default: l_state_d = L_IDLE;
        endcase
    end

    // Output and datapath next values; loading drops in idle so it trails the final write by a cycle.
    always_comb begin
        remaining_d = remaining_q;
        hi_d        = hi_q;
        cur_addr_d  = cur_addr_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        write_d     = 1'b0;
        loading_d   = loading_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (l_state_q)
            L_IDLE: begin
                if (byte_valid_s && byte_data_s == SYNC_BYTE) begin
                    loading_d  = 1'b1;
                    error_d    = 1'b0;
                    cur_addr_d = '0;
                end else begin
                    loading_d = 1'b0;
                end
            end
            L_COUNT: begin
                if (frame_err_s) begin
                    error_d   = 1'b1;
                    loading_d = 1'b0;
                end else if (byte_valid_s) begin
                    remaining_d = (byte_data_s == 8'd0) ? 9'd256 : {1'b0, byte_data_s};
                end else begin
                    remaining_d = remaining_q;
                end
            end
            L_HI: begin
                if (frame_err_s || (byte_valid_s && hi_bad_s)) begin
                    error_d   = 1'b1;
                    loading_d = 1'b0;
                end else if (byte_valid_s) begin
                    hi_d = byte_data_s[HI_BITS-1:0];
                end else begin
                    hi_d = hi_q;
                end
            end
            L_LO: begin
                if (frame_err_s) begin
                    error_d   = 1'b1;
                    loading_d = 1'b0;
                end else if (byte_valid_s) begin
                    write_d     = 1'b1;
                    addr_d      = cur_addr_q;
                    cmd_d       = {hi_q, byte_data_s};
                    remaining_d = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    write_d = 1'b0;
                end
            end
            default: loading_d = 1'b0;
        endcase
    end

    assign prog_bus.program_write   = write_q;
    assign prog_bus.program_address = addr_q;
    assign prog_bus.program_cmd     = cmd_q;
    assign prog_bus.loading         = loading_q;
    assign prog_bus.load_done       = done_q;
    assign prog_bus.load_error      = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised and directed bench for uart_program_loader against a stream-parsing reference model.
module tb_uart_program_loader;

    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    uart_program_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(12)) bus ();

    uart_program_loader #(
        .CLKS_PER_BIT      (CPB),
        .ADDR_WIDTH        (8),
        .INSTRUCTION_WIDTH (4)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .rx       (rx),
        .prog_bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // stream entries: {frame_error, byte}; write entries: {load_done, addr[7:0], cmd[11:0]}
    logic [8:0]  stream[$];
    logic [20:0] obs_q[$];
    logic [20:0] exp_q[$];
    int          checked_n = 0;
    logic        m_err, m_loading;
    logic        done_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every write and check the done/loading relationship around it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.program_write)
                obs_q.push_back({bus.load_done, bus.program_address, bus.program_cmd});
            if (bus.load_done) begin
                check_val("done_with_write", {31'd0, bus.program_write}, 32'd1);
                check_val("loading_at_done", {31'd0, bus.loading}, 32'd1);
            end
            if (done_prev)
                check_val("loading_fall", {31'd0, bus.loading}, 32'd0);
            done_prev <= bus.load_done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    // Parse the whole byte stream since reset: find sync, read count, read hi/lo pairs.
    task automatic model_stream();
        int i;
        int n;
        int cnt;
        int addr;
        bit ok;
        logic [7:0] hi;
        exp_q.delete();
        m_err = 1'b0;
        m_loading = 1'b0;
        i = 0;
        n = stream.size();
        while (i < n) begin
            if (stream[i][8] || stream[i][7:0] != 8'h55) begin
                i++;
                continue;
            end
            i++;
            m_err = 1'b0;
            m_loading = 1'b1;
            if (i >= n) return;
            if (stream[i][8]) begin
                m_err = 1'b1; m_loading = 1'b0; i++;
                continue;
            end
            cnt = (stream[i][7:0] == 8'd0) ? 256 : int'(stream[i][7:0]);
            i++;
            addr = 0;
            ok = 1'b1;
            for (int w = 0; w < cnt && ok; w++) begin
                if (i >= n) return;
                if (stream[i][8] || stream[i][7:4] != 4'd0) begin
                    m_err = 1'b1; m_loading = 1'b0; ok = 1'b0; i++;
                end else begin
                    hi = stream[i][7:0];
                    i++;
                    if (i >= n) return;
                    if (stream[i][8]) begin
                        m_err = 1'b1; m_loading = 1'b0; ok = 1'b0; i++;
                    end else begin
                        exp_q.push_back({(w == cnt - 1), addr[7:0], hi[3:0], stream[i][7:0]});
                        addr++;
                        i++;
                    end
                end
            end
            if (ok) m_loading = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
        stream.push_back({~stop, b});
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_byte(b, 1'b1, CPB + int'($urandom_range(0, 2 * CPB)));
    endtask

    task automatic compare_model(input string tag);
        repeat (3 * CPB) @(negedge clk);
        model_stream();
        check_val({tag, "_write_count"}, obs_q.size(), exp_q.size());
        for (int k = checked_n; k < exp_q.size() && k < obs_q.size(); k++)
            check_val($sformatf("%s_write[%0d]", tag, k), {11'd0, obs_q[k]}, {11'd0, exp_q[k]});
        check_val({tag, "_load_error"}, {31'd0, bus.load_error}, {31'd0, m_err});
        check_val({tag, "_loading"}, {31'd0, bus.loading}, {31'd0, m_loading});
        checked_n = exp_q.size();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_write"},   {31'd0, bus.program_write}, 32'd0);
        check_val({tag, "_addr"},    {24'd0, bus.program_address}, 32'd0);
        check_val({tag, "_cmd"},     {20'd0, bus.program_cmd}, 32'd0);
        check_val({tag, "_loading"}, {31'd0, bus.loading}, 32'd0);
        check_val({tag, "_done"},    {31'd0, bus.load_done}, 32'd0);
        check_val({tag, "_error"},   {31'd0, bus.load_error}, 32'd0);
    endtask

    task automatic clear_model();
        stream.delete();
        obs_q.delete();
        checked_n = 0;
    endtask

    initial begin
        logic [7:0] b;
        int nw;
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word load.
        send_ok(8'h55); send_ok(8'h02); send_ok(8'h0A); send_ok(8'h3C); send_ok(8'h01); send_ok(8'hFF);
        compare_model("two_words");

        // Garbage before sync is ignored.
        send_ok(8'h00); send_ok(8'h13); send_ok(8'hAA);
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h00); send_ok(8'h07);
        compare_model("garbage_first");

        // Bad high byte, then a clean reload clears the error.
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h1A);
        compare_model("bad_hi");
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h00); send_ok(8'h01);
        compare_model("reload");

        // Framing error on the low byte aborts.
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h0A);
        send_byte(8'h5A, 1'b0, 2 * CPB);
        compare_model("frame_err");

        // One-cycle glitch in idle must not start a byte.
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        compare_model("glitch");
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h02); send_ok(8'h34);
        compare_model("after_glitch");

        // Asynchronous reset in the middle of a low byte.
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h0A);
        @(negedge clk) rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        rx = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_ok(8'h55); send_ok(8'h01); send_ok(8'h00); send_ok(8'h03);
        compare_model("post_reset");

        // Randomised loads with occasional garbage, bad high bytes and framing errors.
        for (int s = 0; s < 20; s++) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h54;
                send_ok(b);
            end
            send_ok(8'h55);
            nw = int'($urandom_range(1, 5));
            send_ok(8'(nw));
            for (int w = 0; w < nw; w++) begin
                b = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 11) == 0) b = b | 8'h30;
                send_ok(b);
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 14) == 0) send_byte(b, 1'b0, 2 * CPB);
                else send_ok(b);
            end
            compare_model($sformatf("rand%0d", s));
        end

        // Full 256-word image: count byte 0 means 256, addresses run 00..FF.
        send_ok(8'h55); send_ok(8'h00);
        for (int w = 0; w < 256; w++) begin
            send_byte(8'($urandom_range(0, 15)), 1'b1, CPB);
            send_byte(8'($urandom_range(0, 255)), 1'b1, CPB);
        end
        compare_model("full_256");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Receives a program image over a UART serial line and writes it, word by word, into the processor's text RAM through the `program_write` / `program_cmd` / write-address port. It sits directly upstream of the processor wrapper and is the only writer of program memory. While a load is in progress it raises `loading`, which the top level uses to hold the core in reset.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `ADDR_WIDTH`, 8: program address width.
- `INSTRUCTION_WIDTH`, 4: opcode field width.
- `DATA_WIDTH`, `ADDR_WIDTH + INSTRUCTION_WIDTH`: program word width; must satisfy 9 ≤ `DATA_WIDTH` ≤ 16.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: UART serial input, 8N1, idle high, asynchronous to `clk`.
- `program_write` out 1: one-cycle write strobe to text RAM.
- `program_address` out `ADDR_WIDTH`: write address; valid while `program_write` is high.
- `program_cmd` out `DATA_WIDTH`: program word; valid while `program_write` is high.
- `loading` out 1: high from sync-byte acceptance until load completes or aborts.
- `load_done` out 1: one-cycle pulse marking successful completion.
- `load_error` out 1: sticky error flag; cleared by the next accepted sync byte or by reset.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- **RX FSM** (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`):
  - A falling edge in `RX_IDLE` enters `RX_START`.
  - At `CLKS_PER_BIT/2`, a low sample confirms the start bit; a high sample is a false start and returns to `RX_IDLE`.
  - 8 data bits are sampled LSB first, every `CLKS_PER_BIT`, at bit centre.
  - The stop bit is sampled at its centre. High: `byte_valid` pulses one cycle. Low: `frame_err` pulses one cycle. Either way the FSM returns to `RX_IDLE`.
- **Loader FSM** (`L_IDLE`, `L_COUNT`, `L_HI`, `L_LO`), advancing on `byte_valid`:
  - `L_IDLE`: byte `8'h55` → `L_COUNT`; set `loading`, clear `load_error`, address := 0. Any other byte is ignored.
  - `L_COUNT`: remaining := byte (0 means 256) → `L_HI`.
  - `L_HI`: store the byte. If bits [7:`DATA_WIDTH`−8] are nonzero → abort. Otherwise → `L_LO`.
  - `L_LO`: issue a write with `program_cmd = {hi[DATA_WIDTH-9:0], lo}`, then decrement remaining.
    - remaining was 1 → `L_IDLE` with `load_done`.
    - Otherwise → `L_HI`, address += 1 (wraps modulo 2^`ADDR_WIDTH`).
  - In any state other than `L_IDLE`, `8'h55` is plain data.
- **Abort** (a `frame_err` in any non-idle loader state, or a bad high byte):
  - Set `load_error`, clear `loading`, go to `L_IDLE`, no write.
  - A `frame_err` in `L_IDLE` is ignored.
- **Reset:** all loader and RX state clears immediately; a partial word is discarded.

## Timing
- Reset values:
  - `program_write`, `program_address`, `program_cmd`, `loading`, `load_done`, `load_error` = 0.
  - Both FSMs in their idle states.
- A byte's `byte_valid` pulse comes one cycle after its stop-bit centre sample.
- Latency: `byte_valid` of the low byte in cycle t → `program_write`, `program_address` and `program_cmd` registered and high in cycle t+1.
- `program_address` and `program_cmd` hold their value until the next write.
- `load_done` pulses in the same cycle as the final `program_write`; `loading` falls in the following cycle.
- `loading` rises one cycle after the sync byte's `byte_valid`.
- `load_error` sets one cycle after the offending event.
- At most one write per two received bytes, so no back-pressure is needed.

## Structure
- Package `loader_pkg`: `SYNC_BYTE = 8'h55`, and the `rx_state_t` / `loader_state_t` enums.
- Sub-module `uart_rx`: synchroniser plus RX FSM. Outputs `byte_valid`, `data[7:0]`, `frame_err`.
- The loader FSM lives in `uart_program_loader` itself.

## Test plan (`CLKS_PER_BIT` = 4)
- Send 55 02 0A 3C 01 FF → writes addr 00 cmd A3C, then addr 01 cmd 1FF; `load_done` high with the second write; `loading` low one cycle later; `load_error` stays 0.
- Send 00 13 AA, then 55 01 00 07 → first three bytes ignored; exactly one write, addr 00 cmd 007.
- Send 55 01 1A → `load_error` = 1, `loading` = 0, no write. Then send 55 01 00 01 → error clears, write addr 00 cmd 001.
- Send 55 01 0A, then a low byte with stop bit 0 → abort, `load_error` = 1, no write.
- Pulse `rx` low for 1 cycle in idle → no `byte_valid`, no state change. Assert `reset` low mid-low-byte → all outputs 0; a new load writes from addr 00.
- Send 55 00, then 256 word pairs → 256 writes, addresses 00..FF in order; `load_done` coincides with the addr FF write.
